// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampled UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Clock cycles per sample tick, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; pointers carry an extra wrap bit.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A pop frees the slot in the same cycle, so a push into a full FIFO is still taken.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      pop_data <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok) begin
        rptr     <= rptr + 1'b1;
        pop_data <= mem[rptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampled UART receiver: majority-vote bit recovery, parity/stop checks,
// receive FIFO with a pending/req_data pop handshake.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned PARITY     = 1,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  input  logic                  req_data,
  output logic [DATA_WIDTH-1:0] data_out_rx,
  output logic                  pending_data_rx,
  output logic                  parity_error_rx,
  output logic                  framing_error_rx,
  output logic                  overrun_rx
);

  localparam int unsigned DIV   = baud_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned TW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW    = $clog2(OVERSAMPLE);
  localparam int unsigned BW    = $clog2(DATA_WIDTH);
  localparam int unsigned FW    = DATA_WIDTH + 2;
  localparam parity_e     PMODE = (PARITY == 2) ? PAR_ODD :
                                  (PARITY == 1) ? PAR_EVEN : PAR_NONE;

  rx_state_e             state;
  rx_state_e             state_next;
  logic [1:0]            sync_q;
  logic                  rxs;
  logic                  rxs_prev;
  logic                  fall;
  logic [TW-1:0]         tick_cnt;
  logic                  tick;
  logic [SW-1:0]         scnt;
  logic [1:0]            samp;
  logic                  bit_v;
  logic                  vote_now;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  perr;
  logic                  push;
  logic                  full;
  logic                  empty;
  logic                  pop_ok;
  logic [FW-1:0]         fifo_rdata;

  assign rxs      = sync_q[1];
  assign fall     = rxs_prev && !rxs;
  assign tick     = (tick_cnt == TW'(DIV - 1));
  assign vote_now = tick && (scnt == SW'(OVERSAMPLE / 2 + 1));
  assign bit_v    = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
  assign pop_ok   = req_data && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      ST_IDLE:   if (fall) state_next = ST_START;
      ST_START:  if (vote_now) state_next = bit_v ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (vote_now && bit_cnt == BW'(DATA_WIDTH - 1))
          state_next = (PMODE != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (vote_now) state_next = ST_STOP;
      ST_STOP:
        // Leave at the stop-bit vote so the next start edge is never missed.
        if (vote_now) begin
          push       = 1'b1;
          state_next = ST_IDLE;
        end
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '1;
      rxs_prev <= 1'b1;
      tick_cnt <= '0;
      scnt     <= '0;
      samp     <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      perr     <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], rx};
      rxs_prev <= rxs;
      if (state == ST_IDLE && fall) begin
        tick_cnt <= '0;
        scnt     <= '0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) scnt <= (scnt == SW'(OVERSAMPLE - 1)) ? '0 : scnt + 1'b1;
      end
      if (tick && scnt == SW'(OVERSAMPLE / 2 - 1)) samp[0] <= rxs;
      if (tick && scnt == SW'(OVERSAMPLE / 2))     samp[1] <= rxs;
      if (state == ST_START) begin
        bit_cnt <= '0;
        perr    <= 1'b0;
      end
      if (state == ST_DATA && vote_now) begin
        shreg   <= {bit_v, shreg[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == ST_PARITY && vote_now)
        perr <= (^shreg ^ bit_v) != (PMODE == PAR_ODD);
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({~bit_v, perr, shreg}),
    .pop       (req_data),
    .pop_data  (fifo_rdata),
    .full      (full),
    .empty     (empty)
  );

  assign data_out_rx      = fifo_rdata[DATA_WIDTH-1:0];
  assign parity_error_rx  = fifo_rdata[DATA_WIDTH];
  assign framing_error_rx = fifo_rdata[DATA_WIDTH+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_data_rx <= 1'b0;
      overrun_rx      <= 1'b0;
    end else begin
      pending_data_rx <= !empty;
      if (pop_ok)                overrun_rx <= 1'b0;
      else if (push && full)     overrun_rx <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench: even-parity and odd-parity receivers on separate lines.
module tb_uart_rx_oversample;

  localparam int unsigned CLKF     = 614_400;  // 4 clocks per sample tick
  localparam int          BIT_CLKS = 64;

  logic       clk;
  logic       rst_n;
  logic       rx_e, rx_o;
  logic       req_e, req_o;
  logic [7:0] data_e, data_o;
  logic       pend_e, pend_o;
  logic       perr_e, perr_o;
  logic       ferr_e, ferr_o;
  logic       ovr_e, ovr_o;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_oversample #(
    .DATA_WIDTH (8), .BAUD_RATE (9600), .CLOCK_FREQ (CLKF),
    .PARITY (1), .OVERSAMPLE (16), .FIFO_DEPTH (16)
  ) dut_even (
    .clk (clk), .rst_n (rst_n), .rx (rx_e), .req_data (req_e),
    .data_out_rx (data_e), .pending_data_rx (pend_e),
    .parity_error_rx (perr_e), .framing_error_rx (ferr_e), .overrun_rx (ovr_e)
  );

  uart_rx_oversample #(
    .DATA_WIDTH (8), .BAUD_RATE (9600), .CLOCK_FREQ (CLKF),
    .PARITY (2), .OVERSAMPLE (16), .FIFO_DEPTH (16)
  ) dut_odd (
    .clk (clk), .rst_n (rst_n), .rx (rx_o), .req_data (req_o),
    .data_out_rx (data_o), .pending_data_rx (pend_o),
    .parity_error_rx (perr_o), .framing_error_rx (ferr_o), .overrun_rx (ovr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_o = v;
    else     rx_e = v;
  endtask

  task automatic hold_bit(input bit sel, input logic v);
    drive(sel, v);
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // odd selects odd parity on the wire, flip corrupts it.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit odd,
                            input bit flip, input logic stop_v, input int idle_bits);
    hold_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(sel, d[i]);
    hold_bit(sel, ^d ^ odd ^ flip);
    hold_bit(sel, stop_v);
    drive(sel, 1'b1);
    repeat (idle_bits * BIT_CLKS) @(negedge clk);
  endtask

  task automatic wait_pending(input bit sel, input string tag);
    int n = 0;
    while ((sel ? pend_o : pend_e) !== 1'b1 && n < 4 * BIT_CLKS) begin
      @(negedge clk);
      n++;
    end
    check(tag, sel ? pend_o : pend_e, 1);
  endtask

  task automatic pop(input bit sel);
    @(negedge clk);
    if (sel) req_o = 1'b1; else req_e = 1'b1;
    @(negedge clk);
    req_o = 1'b0;
    req_e = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rx_e  = 1'b1;
    rx_o  = 1'b1;
    req_e = 1'b0;
    req_o = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("rst_data", data_e, 0);
    check("rst_pend", pend_e, 0);
    check("rst_perr", perr_e, 0);
    check("rst_ferr", ferr_e, 0);
    check("rst_ovr",  ovr_e,  0);
    check("rst_pend_odd", pend_o, 0);

    send_frame(0, 8'h55, 0, 0, 1'b1, 1);
    wait_pending(0, "pend_55");
    pop(0);
    check("data_55", data_e, 8'h55);
    check("perr_55", perr_e, 0);
    check("ferr_55", ferr_e, 0);
    repeat (2) @(negedge clk);
    check("pend_after_pop", pend_e, 0);

    send_frame(0, 8'hA5, 0, 1, 1'b1, 1);
    wait_pending(0, "pend_a5");
    pop(0);
    check("data_a5", data_e, 8'hA5);
    check("perr_a5_bad", perr_e, 1);
    check("ferr_a5", ferr_e, 0);

    send_frame(1, 8'hA5, 1, 0, 1'b1, 1);
    wait_pending(1, "pend_odd_a5");
    pop(1);
    check("odd_data_a5", data_o, 8'hA5);
    check("odd_perr_ok", perr_o, 0);
    send_frame(1, 8'h3B, 1, 1, 1'b1, 1);
    wait_pending(1, "pend_odd_3b");
    pop(1);
    check("odd_data_3b", data_o, 8'h3B);
    check("odd_perr_bad", perr_o, 1);

    send_frame(0, 8'h3C, 0, 0, 1'b0, 2);
    wait_pending(0, "pend_3c");
    pop(0);
    check("data_3c", data_e, 8'h3C);
    check("ferr_3c", ferr_e, 1);
    check("perr_3c", perr_e, 0);
    send_frame(0, 8'h81, 0, 0, 1'b1, 1);
    wait_pending(0, "pend_81");
    pop(0);
    check("data_81", data_e, 8'h81);
    check("ferr_81", ferr_e, 0);
    check("perr_81", perr_e, 0);

    repeat (4) @(negedge clk);
    drive(0, 1'b0);
    repeat (12) @(negedge clk);
    drive(0, 1'b1);
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("glitch_pend", pend_e, 0);
    check("glitch_hold", data_e, 8'h81);

    for (int i = 0; i < 17; i++) send_frame(0, 8'(i), 0, 0, 1'b1, 0);
    repeat (BIT_CLKS) @(negedge clk);
    check("full_pend", pend_e, 1);
    check("full_ovr", ovr_e, 1);
    for (int i = 0; i < 16; i++) begin
      pop(0);
      check($sformatf("drain_%0d", i), data_e, i);
      if (i == 0) check("ovr_clear", ovr_e, 0);
    end
    repeat (2) @(negedge clk);
    check("drained_pend", pend_e, 0);
    pop(0);
    check("empty_pop_hold", data_e, 8'h0F);

    hold_bit(0, 1'b0);
    hold_bit(0, 1'b1);
    hold_bit(0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_data", data_e, 0);
    check("midrst_pend", pend_e, 0);
    drive(0, 1'b1);
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("postrst_pend", pend_e, 0);
    send_frame(0, 8'h7E, 0, 0, 1'b1, 1);
    wait_pending(0, "pend_7e");
    pop(0);
    check("data_7e", data_e, 8'h7E);
    check("perr_7e", perr_e, 0);
    check("ferr_7e", ferr_e, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
